// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// A valid/ready handshake starts a conversion. The result is written to bcd_o and ovf_o
// in a single DONE cycle, and both outputs hold that value until the next result.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BIN_W-1:0]      bin_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o,
  output logic                  done_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  // One spare digit, so a carry out of the top digit is never lost before the saturation check.
  localparam int unsigned ScrW = BcdW + 4;
  localparam int unsigned CntW = $clog2(BIN_W);
  localparam logic [31:0] MaxV = 32'(10 ** DIGITS - 1);

  if (BIN_W < 4 || BIN_W > 32) begin : g_bin_w_chk
    $error("bin_to_bcd_seq: BIN_W must be in 4..32");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_digits_chk
    $error("bin_to_bcd_seq: DIGITS must be in 1..8");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [ScrW-1:0]    scr_q, scr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]    bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [ScrW-1:0]    scr_adj;
  logic [31:0]        bin_ext;
  logic               accept;

  assign in_ready_o = (state_q == StIdle) && !rst_i;
  assign accept     = in_valid_i && in_ready_o;
  assign bin_ext    = 32'(bin_i);
  assign bcd_o      = bcd_q;
  assign ovf_o      = ovf_q;
  assign done_o     = done_q;

  // Add 3 to every scratch digit that is 5 or more, ahead of the shift.
  always_comb begin
    scr_adj = scr_q;
    for (int unsigned i = 0; i <= DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d    = bin_i;
          scr_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin_ext > MaxV);
          state_d    = StShift;
        end
      end
      StShift: begin
        {scr_d, shift_d} = {scr_adj, shift_q} << 1;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scr_q[BcdW-1:0];
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers. Reset aborts any conversion and clears the outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

endmodule
